// File: rtl/bank_account_server.sv
// Account database responder: serves one ATM request at a time as an
// atomic search / check / commit transaction over valid/ready channels.
module bank_account_server #(
  parameter int unsigned REG_WIDTH    = 12,
  parameter int unsigned NUM_ACCOUNTS = 4,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned MAX_FAILS    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_we,
  input  logic [IDX_W-1:0]     init_idx,
  input  logic [REG_WIDTH-1:0] init_acct,
  input  logic [REG_WIDTH-1:0] init_pin,
  input  logic [REG_WIDTH-1:0] init_balance,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [REG_WIDTH-1:0] req_acct,
  input  logic [REG_WIDTH-1:0] req_pin,
  input  logic [REG_WIDTH-1:0] req_dst,
  input  logic [REG_WIDTH-1:0] req_amount,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_status,
  output logic [REG_WIDTH-1:0] rsp_balance,
  output logic [REG_WIDTH-1:0] rsp_dst_balance
);

  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

  localparam logic [2:0] OP_DEPOSIT  = 3'd2;
  localparam logic [2:0] OP_WITHDRAW = 3'd3;
  localparam logic [2:0] OP_TRANSFER = 3'd4;

  localparam logic [2:0] ST_OK           = 3'd0;
  localparam logic [2:0] ST_NO_ACCT      = 3'd1;
  localparam logic [2:0] ST_BAD_PIN      = 3'd2;
  localparam logic [2:0] ST_LOCKED       = 3'd3;
  localparam logic [2:0] ST_INSUFFICIENT = 3'd4;
  localparam logic [2:0] ST_NO_DST       = 3'd5;
  localparam logic [2:0] ST_OVERFLOW     = 3'd6;
  localparam logic [2:0] ST_BAD_REQ      = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_CHECK, S_COMMIT, S_RESP
  } state_t;

  state_t state_q, state_d;
  logic   rdy_q, rdy_d;

  // Latched request
  logic [2:0]           r_op_q, r_op_d;
  logic [REG_WIDTH-1:0] r_acct_q, r_acct_d;
  logic [REG_WIDTH-1:0] r_pin_q, r_pin_d;
  logic [REG_WIDTH-1:0] r_dst_q, r_dst_d;
  logic [REG_WIDTH-1:0] r_amt_q, r_amt_d;

  // Search results and decided status
  logic [IDX_W-1:0] k_q, k_d;
  logic             src_found_q, src_found_d;
  logic             dst_found_q, dst_found_d;
  logic [IDX_W-1:0] src_idx_q, src_idx_d;
  logic [IDX_W-1:0] dst_idx_q, dst_idx_d;
  logic [2:0]       status_q, status_d;

  // Response registers
  logic                 rsp_valid_q, rsp_valid_d;
  logic [2:0]           rsp_status_q, rsp_status_d;
  logic [REG_WIDTH-1:0] rsp_balance_q, rsp_balance_d;
  logic [REG_WIDTH-1:0] rsp_dst_balance_q, rsp_dst_balance_d;

  // Account database
  logic                 db_valid_q [NUM_ACCOUNTS];
  logic                 db_valid_d [NUM_ACCOUNTS];
  logic [REG_WIDTH-1:0] db_acct_q  [NUM_ACCOUNTS];
  logic [REG_WIDTH-1:0] db_acct_d  [NUM_ACCOUNTS];
  logic [REG_WIDTH-1:0] db_pin_q   [NUM_ACCOUNTS];
  logic [REG_WIDTH-1:0] db_pin_d   [NUM_ACCOUNTS];
  logic [REG_WIDTH-1:0] db_bal_q   [NUM_ACCOUNTS];
  logic [REG_WIDTH-1:0] db_bal_d   [NUM_ACCOUNTS];
  logic [FAIL_W-1:0]    db_fail_q  [NUM_ACCOUNTS];
  logic [FAIL_W-1:0]    db_fail_d  [NUM_ACCOUNTS];
  logic                 db_lock_q  [NUM_ACCOUNTS];
  logic                 db_lock_d  [NUM_ACCOUNTS];

  // Check-stage arithmetic
  logic [REG_WIDTH-1:0] src_bal_c, dst_bal_c, src_diff_c;
  logic [REG_WIDTH:0]   src_sum_c, dst_sum_c;
  logic [FAIL_W-1:0]    fail_inc_c;
  logic                 amt_op_c;
  logic [2:0]           chk_status_c;

  assign req_ready       = rdy_q && !init_we;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_status      = rsp_status_q;
  assign rsp_balance     = rsp_balance_q;
  assign rsp_dst_balance = rsp_dst_balance_q;

  // Status decision: first failing rule wins; sums carry one extra bit to expose overflow
  always_comb begin
    src_bal_c    = db_bal_q[src_idx_q];
    dst_bal_c    = db_bal_q[dst_idx_q];
    src_sum_c    = {1'b0, src_bal_c} + {1'b0, r_amt_q};
    dst_sum_c    = {1'b0, dst_bal_c} + {1'b0, r_amt_q};
    src_diff_c   = src_bal_c - r_amt_q;
    fail_inc_c   = db_fail_q[src_idx_q] + FAIL_W'(1);
    amt_op_c     = (r_op_q == OP_DEPOSIT) || (r_op_q == OP_WITHDRAW) || (r_op_q == OP_TRANSFER);
    chk_status_c = ST_OK;
    if (r_op_q > OP_TRANSFER) begin
      chk_status_c = ST_BAD_REQ;
    end else if (amt_op_c && (r_amt_q == '0)) begin
      chk_status_c = ST_BAD_REQ;
    end else if (!src_found_q) begin
      chk_status_c = ST_NO_ACCT;
    end else if (db_lock_q[src_idx_q]) begin
      chk_status_c = ST_LOCKED;
    end else if (db_pin_q[src_idx_q] != r_pin_q) begin
      chk_status_c = ST_BAD_PIN;
    end else if ((r_op_q == OP_TRANSFER) && (!dst_found_q || (dst_idx_q == src_idx_q))) begin
      chk_status_c = ST_NO_DST;
    end else if (((r_op_q == OP_WITHDRAW) || (r_op_q == OP_TRANSFER)) && (r_amt_q > src_bal_c)) begin
      chk_status_c = ST_INSUFFICIENT;
    end else if (((r_op_q == OP_DEPOSIT) && src_sum_c[REG_WIDTH]) ||
                 ((r_op_q == OP_TRANSFER) && dst_sum_c[REG_WIDTH])) begin
      chk_status_c = ST_OVERFLOW;
    end
  end

  // Next-state, database update and response computation
  always_comb begin
    state_d           = state_q;
    r_op_d            = r_op_q;
    r_acct_d          = r_acct_q;
    r_pin_d           = r_pin_q;
    r_dst_d           = r_dst_q;
    r_amt_d           = r_amt_q;
    k_d               = k_q;
    src_found_d       = src_found_q;
    dst_found_d       = dst_found_q;
    src_idx_d         = src_idx_q;
    dst_idx_d         = dst_idx_q;
    status_d          = status_q;
    rsp_valid_d       = rsp_valid_q;
    rsp_status_d      = rsp_status_q;
    rsp_balance_d     = rsp_balance_q;
    rsp_dst_balance_d = rsp_dst_balance_q;
    db_valid_d        = db_valid_q;
    db_acct_d         = db_acct_q;
    db_pin_d          = db_pin_q;
    db_bal_d          = db_bal_q;
    db_fail_d         = db_fail_q;
    db_lock_d         = db_lock_q;

    case (state_q)
      S_IDLE: begin
        if (init_we) begin
          db_valid_d[init_idx] = 1'b1;
          db_acct_d[init_idx]  = init_acct;
          db_pin_d[init_idx]   = init_pin;
          db_bal_d[init_idx]   = init_balance;
          db_fail_d[init_idx]  = '0;
          db_lock_d[init_idx]  = 1'b0;
        end else if (req_valid && rdy_q) begin
          r_op_d      = req_op;
          r_acct_d    = req_acct;
          r_pin_d     = req_pin;
          r_dst_d     = req_dst;
          r_amt_d     = req_amount;
          k_d         = '0;
          src_found_d = 1'b0;
          dst_found_d = 1'b0;
          src_idx_d   = '0;
          dst_idx_d   = '0;
          state_d     = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (db_valid_q[k_q] && (db_acct_q[k_q] == r_acct_q) && !src_found_q) begin
          src_found_d = 1'b1;
          src_idx_d   = k_q;
        end
        if (db_valid_q[k_q] && (db_acct_q[k_q] == r_dst_q) && !dst_found_q) begin
          dst_found_d = 1'b1;
          dst_idx_d   = k_q;
        end
        if (k_q == IDX_W'(NUM_ACCOUNTS - 1)) begin
          state_d = S_CHECK;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      S_CHECK: begin
        status_d = chk_status_c;
        state_d  = S_COMMIT;
      end
      S_COMMIT: begin
        rsp_valid_d       = 1'b1;
        rsp_status_d      = status_q;
        rsp_balance_d     = '0;
        rsp_dst_balance_d = '0;
        case (status_q)
          ST_OK: begin
            db_fail_d[src_idx_q] = '0;
            rsp_balance_d        = src_bal_c;
            case (r_op_q)
              OP_DEPOSIT: begin
                db_bal_d[src_idx_q] = src_sum_c[REG_WIDTH-1:0];
                rsp_balance_d       = src_sum_c[REG_WIDTH-1:0];
              end
              OP_WITHDRAW: begin
                db_bal_d[src_idx_q] = src_diff_c;
                rsp_balance_d       = src_diff_c;
              end
              OP_TRANSFER: begin
                db_bal_d[src_idx_q] = src_diff_c;
                db_bal_d[dst_idx_q] = dst_sum_c[REG_WIDTH-1:0];
                rsp_balance_d       = src_diff_c;
                rsp_dst_balance_d   = dst_sum_c[REG_WIDTH-1:0];
              end
              default: ;
            endcase
          end
          ST_BAD_PIN: begin
            db_fail_d[src_idx_q] = fail_inc_c;
            if (fail_inc_c >= FAIL_W'(MAX_FAILS)) begin
              db_lock_d[src_idx_q] = 1'b1;
            end
          end
          ST_NO_DST, ST_INSUFFICIENT, ST_OVERFLOW: begin
            db_fail_d[src_idx_q] = '0;
            rsp_balance_d        = src_bal_c;
          end
          default: ;
        endcase
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rdy_d = (state_d == S_IDLE);
  end

  // State, datapath and database registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      rdy_q             <= 1'b0;
      r_op_q            <= '0;
      r_acct_q          <= '0;
      r_pin_q           <= '0;
      r_dst_q           <= '0;
      r_amt_q           <= '0;
      k_q               <= '0;
      src_found_q       <= 1'b0;
      dst_found_q       <= 1'b0;
      src_idx_q         <= '0;
      dst_idx_q         <= '0;
      status_q          <= '0;
      rsp_valid_q       <= 1'b0;
      rsp_status_q      <= '0;
      rsp_balance_q     <= '0;
      rsp_dst_balance_q <= '0;
      db_valid_q        <= '{default: '0};
      db_acct_q         <= '{default: '0};
      db_pin_q          <= '{default: '0};
      db_bal_q          <= '{default: '0};
      db_fail_q         <= '{default: '0};
      db_lock_q         <= '{default: '0};
    end else begin
      state_q           <= state_d;
      rdy_q             <= rdy_d;
      r_op_q            <= r_op_d;
      r_acct_q          <= r_acct_d;
      r_pin_q           <= r_pin_d;
      r_dst_q           <= r_dst_d;
      r_amt_q           <= r_amt_d;
      k_q               <= k_d;
      src_found_q       <= src_found_d;
      dst_found_q       <= dst_found_d;
      src_idx_q         <= src_idx_d;
      dst_idx_q         <= dst_idx_d;
      status_q          <= status_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_status_q      <= rsp_status_d;
      rsp_balance_q     <= rsp_balance_d;
      rsp_dst_balance_q <= rsp_dst_balance_d;
      db_valid_q        <= db_valid_d;
      db_acct_q         <= db_acct_d;
      db_pin_q          <= db_pin_d;
      db_bal_q          <= db_bal_d;
      db_fail_q         <= db_fail_d;
      db_lock_q         <= db_lock_d;
    end
  end

endmodule

// File: tb/tb_bank_account_server.sv
// Self-checking bench for bank_account_server: directed scenarios with
// constant expectations plus random traffic against a behavioural model.
module tb_bank_account_server;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_we;
  logic [1:0]  init_idx;
  logic [11:0] init_acct, init_pin, init_balance;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_acct, req_pin, req_dst, req_amount;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_status;
  logic [11:0] rsp_balance, rsp_dst_balance;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_valid [4];
  int m_acct  [4];
  int m_pin   [4];
  int m_bal   [4];
  int m_fail  [4];
  int m_lock  [4];

  typedef struct {
    int op; int acct; int pin; int dst; int amt; int st; int b; int db;
  } row_t;

  bank_account_server dut (
    .clk(clk), .rst(rst),
    .init_we(init_we), .init_idx(init_idx), .init_acct(init_acct),
    .init_pin(init_pin), .init_balance(init_balance),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_acct(req_acct), .req_pin(req_pin), .req_dst(req_dst),
    .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance), .rsp_dst_balance(rsp_dst_balance)
  );

  always #5 clk = ~clk;

  // Whole-transaction model: lookup, rule order, arithmetic without wrap
  function automatic void model_exec(input int op, input int acct, input int pin,
                                     input int dst, input int amt,
                                     output int st, output int b, output int db);
    int s = -1;
    int d = -1;
    b = 0; db = 0;
    if (op > 4) begin st = 7; return; end
    if (op >= 2 && amt == 0) begin st = 7; return; end
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] != 0 && m_acct[i] == acct && s < 0) s = i;
      if (m_valid[i] != 0 && m_acct[i] == dst && d < 0) d = i;
    end
    if (s < 0) begin st = 1; return; end
    if (m_lock[s] != 0) begin st = 3; return; end
    if (m_pin[s] != pin) begin
      m_fail[s] = m_fail[s] + 1;
      if (m_fail[s] >= 3) m_lock[s] = 1;
      st = 2;
      return;
    end
    m_fail[s] = 0;
    b = m_bal[s];
    if (op == 4 && (d < 0 || d == s)) st = 5;
    else if ((op == 3 || op == 4) && amt > m_bal[s]) st = 4;
    else if ((op == 2 && m_bal[s] + amt > 4095) || (op == 4 && m_bal[d] + amt > 4095)) st = 6;
    else begin
      st = 0;
      if (op == 2) m_bal[s] = m_bal[s] + amt;
      if (op == 3) m_bal[s] = m_bal[s] - amt;
      if (op == 4) begin
        m_bal[s] = m_bal[s] - amt;
        m_bal[d] = m_bal[d] + amt;
        db = m_bal[d];
      end
      b = m_bal[s];
    end
  endfunction

  task automatic do_init(input int idx, input int acct, input int pin, input int bal);
    @(negedge clk);
    init_we = 1'b1; init_idx = 2'(idx);
    init_acct = 12'(acct); init_pin = 12'(pin); init_balance = 12'(bal);
    @(posedge clk);
    #1 init_we = 1'b0;
    m_valid[idx] = 1; m_acct[idx] = acct; m_pin[idx] = pin;
    m_bal[idx] = bal; m_fail[idx] = 0; m_lock[idx] = 0;
  endtask

  // One full request/response; lat = edges from accept to rsp_valid
  task automatic send(input int op, input int acct, input int pin, input int dst, input int amt,
                      output logic [2:0] st, output logic [11:0] b, output logic [11:0] db,
                      output int lat);
    int n;
    st = 'x; b = 'x; db = 'x; lat = -1;
    @(negedge clk);
    req_op = 3'(op); req_acct = 12'(acct); req_pin = 12'(pin);
    req_dst = 12'(dst); req_amount = 12'(amt); req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept: req_ready=%b expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL response timeout: rsp_valid=%b expected 1", rsp_valid);
      return;
    end
    lat = n;
    st = rsp_status; b = rsp_balance; db = rsp_dst_balance;
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_status, rsp_balance, rsp_dst_balance} !== '0) begin
      errors++;
      $display("FAIL reset outputs: rdy=%b vld=%b st=%0d bal=%0d dbal=%0d expected all 0",
               req_ready, rsp_valid, rsp_status, rsp_balance, rsp_dst_balance);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset idle ready: req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_balance();
    logic [2:0] st; logic [11:0] b, db; int lat;
    do_init(0, 'h101, 'h111, 500);
    do_init(1, 'h202, 'h222, 0);
    do_init(2, 'h303, 'h333, 4000);
    do_init(3, 'h404, 'h444, 'hFFA);
    send(1, 'h101, 'h111, 0, 0, st, b, db, lat);
    checks++;
    if (st !== 3'd0 || b !== 12'd500 || db !== 12'd0) begin
      errors++;
      $display("FAIL balance: st=%0d bal=%0d dbal=%0d expected 0/500/0", st, b, db);
    end
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL latency: got %0d edges expected 6", lat);
    end
  endtask

  task automatic test_deposit_withdraw();
    logic [2:0] st; logic [11:0] b, db; int lat;
    row_t rows [3];
    rows[0] = '{2, 'h202, 'h222, 0, 25, 0, 25, 0};
    rows[1] = '{3, 'h202, 'h222, 0, 25, 0, 0, 0};
    rows[2] = '{3, 'h202, 'h222, 0, 1, 4, 0, 0};
    for (int i = 0; i < 3; i++) begin
      send(rows[i].op, rows[i].acct, rows[i].pin, rows[i].dst, rows[i].amt, st, b, db, lat);
      checks++;
      if (st !== 3'(rows[i].st) || b !== 12'(rows[i].b) || db !== 12'(rows[i].db)) begin
        errors++;
        $display("FAIL dep_wd[%0d]: st=%0d bal=%0d dbal=%0d expected %0d/%0d/%0d",
                 i, st, b, db, rows[i].st, rows[i].b, rows[i].db);
      end
    end
  endtask

  task automatic test_transfer();
    logic [2:0] st; logic [11:0] b, db; int lat;
    row_t rows [5];
    rows[0] = '{4, 'h303, 'h333, 'h101, 100, 0, 3900, 600};
    rows[1] = '{4, 'h303, 'h333, 'h404, 6, 6, 3900, 0};
    rows[2] = '{4, 'h303, 'h333, 'h303, 1, 5, 3900, 0};
    rows[3] = '{4, 'h303, 'h333, 'h999, 1, 5, 3900, 0};
    rows[4] = '{1, 'h404, 'h444, 0, 0, 0, 'hFFA, 0};
    for (int i = 0; i < 5; i++) begin
      send(rows[i].op, rows[i].acct, rows[i].pin, rows[i].dst, rows[i].amt, st, b, db, lat);
      checks++;
      if (st !== 3'(rows[i].st) || b !== 12'(rows[i].b) || db !== 12'(rows[i].db)) begin
        errors++;
        $display("FAIL transfer[%0d]: st=%0d bal=%0d dbal=%0d expected %0d/%0d/%0d",
                 i, st, b, db, rows[i].st, rows[i].b, rows[i].db);
      end
    end
  endtask

  task automatic test_lockout();
    logic [2:0] st; logic [11:0] b, db; int lat;
    row_t rows [4];
    rows[0] = '{0, 'h101, 'h000, 0, 0, 2, 0, 0};
    rows[1] = '{0, 'h101, 'h000, 0, 0, 2, 0, 0};
    rows[2] = '{0, 'h101, 'h000, 0, 0, 2, 0, 0};
    rows[3] = '{0, 'h101, 'h111, 0, 0, 3, 0, 0};
    for (int i = 0; i < 4; i++) begin
      send(rows[i].op, rows[i].acct, rows[i].pin, rows[i].dst, rows[i].amt, st, b, db, lat);
      checks++;
      if (st !== 3'(rows[i].st) || b !== 12'(rows[i].b) || db !== 12'(rows[i].db)) begin
        errors++;
        $display("FAIL lockout[%0d]: st=%0d bal=%0d dbal=%0d expected %0d/%0d/%0d",
                 i, st, b, db, rows[i].st, rows[i].b, rows[i].db);
      end
    end
    do_init(0, 'h101, 'h111, 500);
    send(0, 'h101, 'h111, 0, 0, st, b, db, lat);
    checks++;
    if (st !== 3'd0 || b !== 12'd500) begin
      errors++;
      $display("FAIL unlock by init: st=%0d bal=%0d expected 0/500", st, b);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    n = 0;
    @(negedge clk);
    req_op = 3'd1; req_acct = 12'h303; req_pin = 12'h333; req_dst = '0; req_amount = '0;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    // Offer a second request while the response is stalled
    @(negedge clk);
    req_op = 3'd2; req_acct = 12'h303; req_pin = 12'h333; req_amount = 12'd5; req_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_status !== 3'd0 || rsp_balance !== 12'd3900 ||
          rsp_dst_balance !== 12'd0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: vld=%b st=%0d bal=%0d dbal=%0d rdy=%b expected 1/0/3900/0/0",
                 i, rsp_valid, rsp_status, rsp_balance, rsp_dst_balance, req_ready);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake drop: rsp_valid=%b expected 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready after handshake: req_ready=%b expected 1", req_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stalled request accepted: rsp_valid high %0d cycles expected 0", bad);
    end
  endtask

  task automatic test_errors();
    logic [2:0] st; logic [11:0] b, db; int lat;
    row_t rows [3];
    rows[0] = '{1, 'h777, 'h111, 0, 0, 1, 0, 0};
    rows[1] = '{6, 'h101, 'h111, 0, 5, 7, 0, 0};
    rows[2] = '{2, 'h101, 'h111, 0, 0, 7, 0, 0};
    for (int i = 0; i < 3; i++) begin
      send(rows[i].op, rows[i].acct, rows[i].pin, rows[i].dst, rows[i].amt, st, b, db, lat);
      checks++;
      if (st !== 3'(rows[i].st) || b !== 12'(rows[i].b) || db !== 12'(rows[i].db)) begin
        errors++;
        $display("FAIL errors[%0d]: st=%0d bal=%0d dbal=%0d expected %0d/%0d/%0d",
                 i, st, b, db, rows[i].st, rows[i].b, rows[i].db);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] st; logic [11:0] b, db; int lat;
    do_init(0, 'h10A, 'h1A1, 1000);
    do_init(1, 'h20B, 'h2B2, 50);
    do_init(2, 'h30C, 'h3C3, 4000);
    do_init(3, 'h40D, 'h4D4, 3000);
    for (int it = 0; it < 60; it++) begin
      int op, si, di, acct, pin, dst, amt, e_st, e_b, e_db;
      op   = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
      si   = $urandom_range(0, 3);
      di   = $urandom_range(0, 3);
      acct = ($urandom_range(0, 9) < 9) ? m_acct[si] : int'($urandom_range(0, 4095));
      pin  = ($urandom_range(0, 9) < 8) ? m_pin[si] : int'($urandom_range(0, 4095));
      dst  = ($urandom_range(0, 9) < 9) ? m_acct[di] : int'($urandom_range(0, 4095));
      amt  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 200));
      model_exec(op, acct, pin, dst, amt, e_st, e_b, e_db);
      send(op, acct, pin, dst, amt, st, b, db, lat);
      checks++;
      if (st !== 3'(e_st) || b !== 12'(e_b) || db !== 12'(e_db) || lat != 6) begin
        errors++;
        $display("FAIL random[%0d] op=%0d acct=%h: st=%0d bal=%0d dbal=%0d lat=%0d expected %0d/%0d/%0d/6",
                 it, op, acct, st, b, db, lat, e_st, e_b, e_db);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [2:0] st; logic [11:0] b, db; int lat;
    int n;
    int seen;
    n = 0;
    @(negedge clk);
    req_op = 3'd4; req_acct = 12'h30C; req_pin = 12'h3C3; req_dst = 12'h10A; req_amount = 12'd10;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_status, rsp_balance, rsp_dst_balance} !== '0) begin
      errors++;
      $display("FAIL midflight reset outputs: rdy=%b vld=%b st=%0d bal=%0d dbal=%0d expected all 0",
               req_ready, rsp_valid, rsp_status, rsp_balance, rsp_dst_balance);
    end
    @(negedge clk) rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL aborted response: rsp_valid high %0d cycles expected 0", seen);
    end
    send(1, 'h101, 'h111, 0, 0, st, b, db, lat);
    checks++;
    if (st !== 3'd1 || b !== 12'd0) begin
      errors++;
      $display("FAIL cleared database: st=%0d bal=%0d expected 1/0", st, b);
    end
  endtask

  task automatic test_init_priority();
    logic [2:0] st; logic [11:0] b, db; int lat;
    int seen;
    @(negedge clk);
    init_we = 1'b1; init_idx = 2'd1; init_acct = 12'h505; init_pin = 12'h555; init_balance = 12'd77;
    req_op = 3'd1; req_acct = 12'h505; req_pin = 12'h555; req_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL init priority: req_ready=%b expected 0", req_ready);
    end
    @(posedge clk);
    #1 init_we = 1'b0; req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL request taken during init: rsp_valid high %0d cycles expected 0", seen);
    end
    send(1, 'h505, 'h555, 0, 0, st, b, db, lat);
    checks++;
    if (st !== 3'd0 || b !== 12'd77) begin
      errors++;
      $display("FAIL init applied: st=%0d bal=%0d expected 0/77", st, b);
    end
  endtask

  initial begin
    rst = 1'b1; init_we = 1'b0; init_idx = '0; init_acct = '0; init_pin = '0; init_balance = '0;
    req_valid = 1'b0; req_op = '0; req_acct = '0; req_pin = '0; req_dst = '0; req_amount = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0; m_acct[i] = 0; m_pin[i] = 0; m_bal[i] = 0; m_fail[i] = 0; m_lock[i] = 0;
    end
    test_reset();
    test_balance();
    test_deposit_withdraw();
    test_transfer();
    test_lockout();
    test_backpressure();
    test_errors();
    test_random();
    test_reset_midflight();
    test_init_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bank_account_server.md
Name: bank_account_server

Overview:
- Responder side of the ATM account-access interface. Holds the account database (number, PIN, balance, lockout state) in registers.
- Serves one ATM request at a time over a valid/ready request channel and a valid/ready response channel.
- Performs lookup, PIN check, balance read, deposit, withdraw and transfer as atomic read-check-write transactions.
- Replaces file-loaded database access with an explicit init write port.

Parameters:
- REG_WIDTH, 12, width of account number, PIN, amounts and balances.
- NUM_ACCOUNTS, 4, number of database entries.
- IDX_W, 2, index width; must equal ceil(log2(NUM_ACCOUNTS)).
- MAX_FAILS, 3, consecutive bad-PIN attempts that lock an account.

Ports:
- clk, input, 1, clock; all logic is on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- init_we, input, 1, write one database entry; honoured only in IDLE.
- init_idx, input, IDX_W, entry index written.
- init_acct, input, REG_WIDTH, account number for the entry.
- init_pin, input, REG_WIDTH, PIN for the entry.
- init_balance, input, REG_WIDTH, initial balance for the entry.
- req_valid, input, 1, request present.
- req_ready, output, 1, server can accept a request.
- req_op, input, 3, operation: 0 VERIFY, 1 BALANCE, 2 DEPOSIT, 3 WITHDRAW, 4 TRANSFER; 5-7 illegal.
- req_acct, input, REG_WIDTH, source account number.
- req_pin, input, REG_WIDTH, source PIN.
- req_dst, input, REG_WIDTH, destination account (TRANSFER only).
- req_amount, input, REG_WIDTH, amount (ops 2-4).
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, ATM consumes the response.
- rsp_status, output, 3, response status: 0 OK, 1 NO_ACCT, 2 BAD_PIN, 3 LOCKED, 4 INSUFFICIENT, 5 NO_DST, 6 OVERFLOW, 7 BAD_REQ.
- rsp_balance, output, REG_WIDTH, source balance after the transaction.
- rsp_dst_balance, output, REG_WIDTH, destination balance after the transaction.

Behaviour:
- Reset (async) clears:
  - all entries: valid=0, acct=0, pin=0, balance=0, fail count=0, locked=0;
  - outputs: req_ready=0, rsp_valid=0, rsp_status=0, rsp_balance=0, rsp_dst_balance=0;
  - FSM goes to IDLE.
- A reset mid-transaction aborts it with no response and no partial update.
- Init write:
  - In IDLE, init_we writes entry init_idx and sets valid=1, fail count=0, locked=0.
  - init_we has priority: req_ready=0 in any cycle init_we=1.
  - init_we outside IDLE is ignored.
- FSM states: IDLE, SEARCH, CHECK, COMMIT, RESP.
- IDLE: req_ready=1 (unless init_we). On req_valid&&req_ready, latch all req_* fields, go to SEARCH.
- SEARCH: one entry per cycle, k=0..NUM_ACCOUNTS-1, lasts exactly NUM_ACCOUNTS cycles.
  - Entry k is compared against the latched acct and dst, in parallel.
  - Only valid entries match. The lowest-index match wins for each of src and dst.
- CHECK: one cycle, computes status by first failing rule in this order:
  1. req_op>4 -> BAD_REQ.
  2. Ops 2-4 with req_amount==0 -> BAD_REQ.
  3. Source not found -> NO_ACCT.
  4. Source locked -> LOCKED.
  5. PIN mismatch -> BAD_PIN; fail count +1; locked=1 when count reaches MAX_FAILS.
  6. TRANSFER with dst not found, or dst index == src index -> NO_DST.
  7. WITHDRAW/TRANSFER with amount > src balance -> INSUFFICIENT (amount == balance is allowed).
  8. DEPOSIT carry out of REG_WIDTH, or TRANSFER dst carry out -> OVERFLOW.
  9. Otherwise OK; fail count cleared on any PIN match.
- COMMIT: one cycle.
  - Only on OK: DEPOSIT src+=amt; WITHDRAW src-=amt; TRANSFER src-=amt and dst+=amt, both in the same edge.
  - Any non-OK status leaves all balances unchanged.
  - Drive response registers, go to RESP.
- Response values:
  - rsp_balance = post-commit src balance when the PIN matched; 0 for NO_ACCT, BAD_PIN, LOCKED, and for BAD_REQ before lookup.
  - rsp_dst_balance = post-commit dst balance for TRANSFER OK, else 0.
- RESP:
  - rsp_valid=1 with fields held stable until rsp_ready; on rsp_valid&&rsp_ready return to IDLE.
  - req_ready=0 throughout SEARCH..RESP.
- Latency: rsp_valid rises on the (NUM_ACCOUNTS+2)th rising edge after the accept edge, i.e. 6 edges with defaults. Next accept is possible the cycle after the handshake.
- All arithmetic is unsigned REG_WIDTH with no wrap: overflow/underflow are rejected, never truncated.

Test Plan:
- Init entries 0..3 = (0x101,0x111,500),(0x202,0x222,0),(0x303,0x333,4000),(0x404,0x444,0xFFA); BALANCE acct 0x101 pin 0x111 -> OK, rsp_balance=500, rsp_valid exactly 6 edges after accept.
- DEPOSIT 0x202 pin 0x222 amt 25 -> OK, bal 25. WITHDRAW 0x202 amt 25 -> OK, bal 0. WITHDRAW amt 1 -> INSUFFICIENT, bal 0.
- TRANSFER 0x303->0x101 amt 100 -> OK, rsp_balance=3900, rsp_dst_balance=600. TRANSFER 0x303->0x404 amt 6 -> OVERFLOW, both balances unchanged. TRANSFER 0x303->0x303 -> NO_DST. TRANSFER 0x303->0x999 -> NO_DST.
- VERIFY 0x101 with pin 0x000 three times -> BAD_PIN x3. Then correct PIN -> LOCKED, rsp_balance=0. Re-init entry 0 -> VERIFY OK.
- Hold rsp_ready=0 for 10 cycles: rsp_valid and fields stable, req_ready=0, a new req_valid is not accepted. Unknown acct 0x777 -> NO_ACCT. req_op=6 -> BAD_REQ. DEPOSIT amt 0 -> BAD_REQ.
- Assert rst during SEARCH of a TRANSFER: no response, all outputs 0, database cleared (BALANCE 0x101 -> NO_ACCT). init_we asserted together with req_valid in IDLE -> init performed, request not accepted that cycle.
